// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store memory stage.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } lsu_state_e;

    // Size 2'b11 is illegal and therefore always reported as misaligned.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Request, data-memory and response signals of lsu_mem_stage.
// slave is the stage's own view; master is the view of its environment.
interface lsu_mem_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output resp_valid, resp_rdata, resp_err, busy
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store enables/data replication and load extraction/extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        sign;

    assign shifted = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;
        sign    = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                sign    = ~unsigned_i & shifted[7];
                rdata_o = {{24{sign}}, shifted[7:0]};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << offset_i;
                wdata_o = {2{wdata_i[15:0]}};
                sign    = ~unsigned_i & shifted[15];
                rdata_o = {{16{sign}}, shifted[15:0]};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// RV32I load/store stage: one access per handshake, word-addressed memory port, 1-cycle response.
// Optional memory wait timeout is compiled in with `define LSU_TIMEOUT_EN.
module lsu_mem_stage
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_stage_if.slave bus
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be non-zero");
    end

    lsu_state_e  state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        in_req;

    lsu_align u_align (
        .size_i     (size_q),
        .offset_i   (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (bus.mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned    CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic            expired;

    assign expired = (cnt_q == CntLast);
`endif

    // Memory port is decoded from latched request fields, never from req_* directly.
    assign in_req         = (state_q == StReq);
    assign bus.req_ready  = (state_q == StIdle);
    assign bus.busy       = (state_q != StIdle);
    assign bus.mem_req    = in_req;
    assign bus.mem_we     = in_req & we_q;
    assign bus.mem_addr   = in_req ? {addr_q[31:2], 2'b00} : '0;
    assign bus.mem_be     = in_req ? al_be : '0;
    assign bus.mem_wdata  = in_req ? al_wdata : '0;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        size_q  <= bus.req_size;
                        we_q    <= bus.req_we;
                        uns_q   <= bus.req_unsigned;
`ifdef LSU_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                        if (lsu_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            state_q <= StResp;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (bus.mem_gnt) begin
`ifdef LSU_TIMEOUT_EN
                        cnt_q <= '0;
`endif
                        if (we_q) begin
                            state_q <= StResp;
                            err_q   <= 1'b0;
                            rdata_q <= '0;
                        end else begin
                            state_q <= StWait;
                        end
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (expired) begin
                        state_q <= StResp;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
                StWait: begin
                    if (bus.mem_rvalid) begin
                        state_q <= StResp;
                        err_q   <= 1'b0;
                        rdata_q <= al_rdata;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (expired) begin
                        state_q <= StResp;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
`endif
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
